// File: rtl/deit_tile_scheduler.sv
// Tile-loop scheduler for a DeiT matmul tile engine: walks K steps inside N passes,
// sequencing input load, core start, and output drain handshakes.
module deit_tile_scheduler #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [IDX_W-1:0] i_k_tiles,
    input  logic [IDX_W-1:0] i_n_tiles,
    output logic             o_in_req,
    input  logic             i_in_done,
    output logic             o_core_start,
    output logic             o_acc_mode,
    output logic             o_out_en,
    output logic [IDX_W-1:0] o_in_k_idx,
    output logic [IDX_W-1:0] o_wt_k_idx,
    output logic [IDX_W-1:0] o_wt_n_idx,
    input  logic             i_core_done,
    input  logic             i_out_done,
    output logic             o_busy,
    output logic             o_done,
    output logic [15:0]      o_step_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_IN = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_k;
    logic [IDX_W-1:0] r_n;
    logic [IDX_W-1:0] r_kt;
    logic [IDX_W-1:0] r_nt;
    logic [15:0]      r_step_cnt;
    logic             r_out_flag;

    logic w_k_last;
    logic w_n_last;
    logic w_step_active;

    // Bounds are at least 1 whenever these are consulted, so the subtraction cannot wrap.
    assign w_k_last      = (r_k == r_kt - IDX_W'(1));
    assign w_n_last      = (r_n == r_nt - IDX_W'(1));
    assign w_step_active = (r_state == S_START) || (r_state == S_COMPUTE) || (r_state == S_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_n        <= '0;
            r_kt       <= '0;
            r_nt       <= '0;
            r_step_cnt <= '0;
            r_out_flag <= 1'b0;
        end else if (i_abort && r_state != S_IDLE) begin
            r_state    <= S_IDLE;
            r_out_flag <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_kt       <= i_k_tiles;
                        r_nt       <= i_n_tiles;
                        r_k        <= '0;
                        r_n        <= '0;
                        r_step_cnt <= '0;
                        r_state    <= (i_k_tiles == '0 || i_n_tiles == '0) ? S_DONE : S_LOAD_IN;
                    end
                end
                S_LOAD_IN: begin
                    if (i_in_done) begin
                        r_state    <= S_START;
                        r_out_flag <= 1'b0;
                    end
                end
                S_START: begin
                    if (i_out_done) r_out_flag <= 1'b1;
                    r_state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (i_out_done) r_out_flag <= 1'b1;
                    if (i_core_done) begin
                        if (r_step_cnt != 16'hFFFF) r_step_cnt <= r_step_cnt + 16'd1;
                        r_state <= w_k_last ? S_DRAIN : S_NEXT;
                    end
                end
                S_DRAIN: begin
                    if (i_out_done) r_out_flag <= 1'b1;
                    if (r_out_flag || i_out_done) r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (!w_k_last) begin
                        r_k     <= r_k + IDX_W'(1);
                        r_state <= S_LOAD_IN;
                    end else if (w_n_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_k     <= '0;
                        r_n     <= r_n + IDX_W'(1);
                        r_state <= S_LOAD_IN;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_req     = (r_state == S_LOAD_IN);
    assign o_core_start = (r_state == S_START);
    assign o_acc_mode   = w_step_active && (r_k != '0);
    assign o_out_en     = w_step_active && w_k_last;
    assign o_in_k_idx   = r_k;
    assign o_wt_k_idx   = r_k;
    assign o_wt_n_idx   = r_n;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_step_cnt   = r_step_cnt;

endmodule

// File: tb/tb_deit_tile_scheduler.sv
// Scoreboard bench for deit_tile_scheduler: the driver queues expected step/done records,
// a negedge monitor checks them whenever o_core_start or o_done appears.
module tb_deit_tile_scheduler;

    localparam int IDX_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_start = 1'b0;
    logic             i_abort = 1'b0;
    logic [IDX_W-1:0] i_k_tiles = '0;
    logic [IDX_W-1:0] i_n_tiles = '0;
    logic             i_in_done = 1'b0;
    logic             i_core_done = 1'b0;
    logic             i_out_done = 1'b0;
    logic             o_in_req, o_core_start, o_acc_mode, o_out_en, o_busy, o_done;
    logic [IDX_W-1:0] o_in_k_idx, o_wt_k_idx, o_wt_n_idx;
    logic [15:0]      o_step_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic             acc;
        logic             out_en;
        logic [IDX_W-1:0] k;
        logic [IDX_W-1:0] n;
    } step_t;

    step_t step_q[$];
    int    done_q[$];

    deit_tile_scheduler #(.IDX_W(IDX_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_k_tiles    (i_k_tiles),
        .i_n_tiles    (i_n_tiles),
        .o_in_req     (o_in_req),
        .i_in_done    (i_in_done),
        .o_core_start (o_core_start),
        .o_acc_mode   (o_acc_mode),
        .o_out_en     (o_out_en),
        .o_in_k_idx   (o_in_k_idx),
        .o_wt_k_idx   (o_wt_k_idx),
        .o_wt_n_idx   (o_wt_n_idx),
        .i_core_done  (i_core_done),
        .i_out_done   (i_out_done),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_step_cnt   (o_step_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a step start or a done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_core_start) begin
                if (step_q.size() == 0) begin
                    chk("core_start_unexpected", 1, 0);
                end else begin
                    step_t e;
                    e = step_q.pop_front();
                    chk("step_acc_outen", {o_acc_mode, o_out_en}, {e.acc, e.out_en});
                    chk("step_wt_k", o_wt_k_idx, e.k);
                    chk("step_wt_n", o_wt_n_idx, e.n);
                    chk("step_in_k", o_in_k_idx, e.k);
                end
            end
            if (o_done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    int e;
                    e = done_q.pop_front();
                    chk("done_step_cnt", o_step_cnt, e);
                end
            end
        end
    end

    // Runs one job with a responder for the load/core/out handshakes.
    task automatic run_job(input int kt, input int nt, input int in_delay, input bit coincide,
                           input int abort_step, input bit midstart, input bit rst_drain);
        int  limit, step_idx, in_wait, delay_cur, cs_cnt, req_cnt, done_cnt, cycles;
        bit  comp_pend, drain_pend, aborted, finished;
        limit = (abort_step > 0) ? abort_step : kt * nt;
        for (int n = 0; n < nt; n++)
            for (int k = 0; k < kt; k++)
                if (n * kt + k < limit)
                    step_q.push_back('{acc: (k != 0), out_en: (k == kt - 1),
                                       k: IDX_W'(k), n: IDX_W'(n)});
        if (abort_step == 0 && !rst_drain) done_q.push_back(kt * nt);

        step_idx = 0; in_wait = 0; delay_cur = in_delay; cs_cnt = 0; req_cnt = 0;
        done_cnt = 0; comp_pend = 0; drain_pend = 0; aborted = 0; finished = 0;

        @(negedge clk);
        i_start = 1'b1; i_k_tiles = IDX_W'(kt); i_n_tiles = IDX_W'(nt);
        for (cycles = 1; cycles <= 5000 && !finished; cycles++) begin
            @(negedge clk);
            i_start = 1'b0; i_in_done = 1'b0; i_core_done = 1'b0;
            i_out_done = 1'b0; i_abort = 1'b0;
            if (aborted) begin
                chk("abort_busy_low", o_busy, 0);
                chk("abort_no_done", o_done, 0);
                chk("abort_outputs_low", {o_in_req, o_core_start, o_acc_mode, o_out_en}, 0);
                finished = 1;
            end else begin
                if (comp_pend) begin
                    comp_pend = 0;
                    step_idx++;
                    if (step_idx == abort_step) begin
                        i_abort = 1'b1;
                        aborted = 1;
                    end else begin
                        i_core_done = 1'b1;
                        if (step_idx % kt == 0) begin
                            if (coincide) i_out_done = 1'b1;
                            else drain_pend = 1;
                        end
                        if (midstart && step_idx == 1) begin
                            i_start = 1'b1; i_k_tiles = 8'd7; i_n_tiles = 8'd7;
                        end
                    end
                end else if (drain_pend) begin
                    drain_pend = 0;
                    if (rst_drain) begin
                        rst = 1'b1;
                        #1;
                        chk("rst_outputs_zero",
                            {o_in_req, o_core_start, o_acc_mode, o_out_en, o_busy, o_done,
                             o_in_k_idx, o_wt_k_idx, o_wt_n_idx, o_step_cnt}, 0);
                        repeat (3) @(negedge clk);
                        rst = 1'b0;
                        repeat (10) begin
                            @(negedge clk);
                            if (o_done || o_busy) done_cnt++;
                        end
                        chk("rst_no_done_idle", done_cnt, 0);
                        finished = 1;
                    end else begin
                        i_out_done = 1'b1;
                    end
                end
                if (!finished) begin
                    if (o_core_start) begin
                        cs_cnt++;
                        comp_pend = 1;
                    end
                    if (o_in_req) begin
                        req_cnt++;
                        if (in_wait >= delay_cur) begin
                            if (delay_cur > 0) chk("no_start_during_hold", cs_cnt, 0);
                            i_in_done = 1'b1;
                            in_wait = 0;
                            delay_cur = 0;
                        end else begin
                            in_wait++;
                        end
                    end
                    if (o_done) begin
                        done_cnt++;
                        if (kt == 0 || nt == 0) chk("zero_done_latency", cycles, 1);
                        finished = 1;
                    end
                end
            end
        end
        if (!finished) chk("job_timeout", 0, 1);
        i_start = 1'b0; i_in_done = 1'b0; i_core_done = 1'b0; i_out_done = 1'b0; i_abort = 1'b0;

        if (abort_step == 0 && !rst_drain) begin
            chk("core_start_count", cs_cnt, kt * nt);
            chk("in_req_cycles", req_cnt, in_delay + kt * nt);
            chk("done_count", done_cnt, 1);
            repeat (3) @(negedge clk);
            chk("step_cnt_hold", o_step_cnt, kt * nt);
            chk("idle_after_done", o_busy, 0);
        end
        chk("step_queue_drained", step_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero",
            {o_in_req, o_core_start, o_acc_mode, o_out_en, o_busy, o_done,
             o_in_k_idx, o_wt_k_idx, o_wt_n_idx, o_step_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_job(2, 2, 0, 1'b0, 0, 1'b0, 1'b0);   // basic 2x2 job
        run_job(2, 2, 0, 1'b1, 0, 1'b0, 1'b0);   // out_done coincident with core_done
        run_job(0, 3, 0, 1'b0, 0, 1'b0, 1'b0);   // zero K bound
        run_job(2, 0, 0, 1'b0, 0, 1'b0, 1'b0);   // zero N bound
        run_job(2, 2, 0, 1'b0, 2, 1'b0, 1'b0);   // abort in COMPUTE of step 2
        run_job(1, 1, 0, 1'b0, 0, 1'b0, 1'b0);   // fresh job after abort
        run_job(2, 1, 50, 1'b0, 0, 1'b1, 1'b0);  // held load + ignored mid-job start
        run_job(2, 1, 0, 1'b0, 0, 1'b0, 1'b1);   // reset while draining
        run_job(1, 3, 0, 1'b0, 0, 1'b0, 1'b0);
        run_job(255, 1, 0, 1'b0, 0, 1'b0, 1'b0); // maximum K bound

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deit_tile_scheduler.md
DEIT_TILE_SCHEDULER -- requirements
Module: deit_tile_scheduler

Interface
REQ-001 SHALL have parameter IDX_W, default 8, meaning width of the K/N tile counts and indices.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port i_start, input, 1, one-cycle job start pulse.
REQ-005 SHALL have port i_abort, input, 1, synchronous job abort.
REQ-006 SHALL have ports i_k_tiles and i_n_tiles, input, IDX_W each, tile-loop bounds, sampled on an accepted i_start.
REQ-007 SHALL have port o_in_req, output, 1, request to load input tile o_in_k_idx.
REQ-008 SHALL have port i_in_done, input, 1, pulse: input tile fully received (TLAST beat accepted).
REQ-009 SHALL have port o_core_start, output, 1, one-cycle compute-core start pulse.
REQ-010 SHALL have ports o_acc_mode and o_out_en, output, 1 each, accumulate-mode and PPU-output-enable controls.
REQ-011 SHALL have ports o_in_k_idx, o_wt_k_idx and o_wt_n_idx, output, IDX_W each, current tile indices.
REQ-012 SHALL have port i_core_done, input, 1, pulse: compute core finished the current K step.
REQ-013 SHALL have port i_out_done, input, 1, pulse: output stream for the current N tile drained (TLAST sent).
REQ-014 SHALL have ports o_busy, output, 1, high whenever not IDLE, and o_done, output, 1, job-complete pulse.
REQ-015 SHALL have port o_step_cnt, output, 16, count of completed K steps in the current job.

Function
REQ-016 SHALL implement states IDLE, LOAD_IN, START, COMPUTE, DRAIN, NEXT and DONE.
REQ-017 SHALL, in IDLE on i_start, latch both loop bounds, clear k, n and o_step_cnt, and enter LOAD_IN on the next edge.
REQ-018 SHALL, when i_start arrives with either latched bound equal to 0, go IDLE->DONE directly, with no o_in_req and no o_core_start.
REQ-019 SHALL hold o_in_req high throughout LOAD_IN with o_in_k_idx=k, and move to START on the edge where i_in_done=1.
REQ-020 SHALL assert o_core_start for exactly the one START cycle, then enter COMPUTE.
REQ-021 SHALL drive o_acc_mode=(k!=0), o_out_en=(k==K-1), o_wt_k_idx=k and o_wt_n_idx=n, stable from START entry until the state is left.
REQ-022 SHALL, in COMPUTE on i_core_done, increment o_step_cnt, then enter DRAIN if o_out_en=1, else NEXT.
REQ-023 SHALL keep a sticky out-done flag, cleared on START entry and set on any i_out_done seen in START, COMPUTE or DRAIN.
REQ-024 SHALL leave DRAIN for NEXT once the sticky flag is set, including the case where i_out_done coincides with i_core_done.
REQ-025 SHALL advance in NEXT as follows: if k<K-1, k+1; else k=0 and n+1; after n=N-1 and k=K-1 enter DONE, otherwise LOAD_IN.
REQ-026 SHALL reload the input tile in LOAD_IN on every K step, including on each new N pass.
REQ-027 SHALL assert o_done for exactly the one DONE cycle, then return to IDLE.
REQ-028 SHALL ignore i_start while o_busy=1.
REQ-029 SHALL ignore i_in_done, i_core_done and i_out_done in states that do not wait on them, except for the sticky flag in REQ-023.
REQ-030 SHALL, on i_abort in any non-IDLE state, enter IDLE on the next edge with all pulses and requests low, and with no o_done.
REQ-031 SHALL give i_abort priority over every other event in the same cycle, including i_start and any done pulse.
REQ-032 SHALL saturate o_step_cnt at 16'hFFFF.
REQ-033 SHALL hold o_step_cnt after DONE until the next accepted i_start.
REQ-034 SHALL handle loop bounds up to 2^IDX_W-1 without index wrap.

Reset
REQ-035 SHALL, while rst=1, force state IDLE and all outputs 0, including all indices and o_step_cnt, and clear the sticky flag.
REQ-036 SHALL, on rst asserted mid-job, discard the job with no o_done, and SHALL require a new i_start after reset release.

Verification
REQ-037 SHALL cover a K=2, N=2 job with prompt done pulses:
- o_core_start count = 4.
- (acc,out_en) per step = (0,0),(1,1),(0,0),(1,1).
- (k,n) indices = (0,0),(1,0),(0,1),(1,1).
- Exactly one o_done; o_step_cnt = 4.
REQ-038 SHALL cover i_out_done arriving in the same cycle as i_core_done on a last-K step: no hang, and the scheduler proceeds to NEXT.
REQ-039 SHALL cover i_start with i_k_tiles=0: o_done one cycle later, with zero o_in_req and zero o_core_start.
REQ-040 SHALL cover i_abort asserted in COMPUTE of step 2: IDLE next cycle, o_busy=0, no o_done; a fresh K=1, N=1 job then completes with o_step_cnt=1.
REQ-041 SHALL cover a second i_start pulsed mid-job (ignored, job unchanged) and i_in_done held off 50 cycles (o_in_req stays high and no o_core_start).
REQ-042 SHALL cover rst asserted in DRAIN: all outputs 0 immediately, state IDLE, and no o_done after release.
